c3aibadapt_txasync_lockqual: RTL

- Receives the asynchronous PLL lock status (pld_pma_fpll_lc_lock) from the PCS side before it is forwarded across AIB.
- Synchronizes the status into the adapter config clock and qualifies it with a programmable stable-high filter.
- Drives the qualified lock toward the AIB direct-async stage.
- Records lock-loss events in a sticky flag and a saturating counter for CSR readback.

---
 rtl/c3aibadapt_lockqual_pkg.sv | 23 ++
 rtl/c3lib_bitsync.sv | 38 +++
 rtl/c3aibadapt_txasync_lockqual.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/c3aibadapt_lockqual_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : c3aibadapt_lockqual_pkg
//  Description : Shared definitions for the TX async PLL-lock qualifier.
//                Holds the lock FSM state encoding (also the debug value
//                driven on lock_state) and the default counter widths.
//  Revision    : 1.0  initial release
// ============================================================================
package c3aibadapt_lockqual_pkg;

    // Default widths of the qualification counter and loss-event counter
    localparam int LQ_QUAL_CNT_W_DEF = 10;
    localparam int LQ_LOSS_CNT_W_DEF = 8;

    // Lock FSM encoding; the raw value is exported for debug
    typedef enum logic [1:0] {
        LQ_UNLOCKED = 2'b00,
        LQ_QUALIFY  = 2'b01,
        LQ_LOCKED   = 2'b10
    } lq_state_e;

endpackage : c3aibadapt_lockqual_pkg
`default_nettype wire

// File: rtl/c3lib_bitsync.sv
`default_nettype none
// ============================================================================
//  Module      : c3lib_bitsync
//  Description : Common multi-flop bit synchronizer. Each bit of data_in is
//                passed through a SYNCSTAGE-deep flop chain clocked by clk.
//                Latency is SYNCSTAGE cycles. SYNCSTAGE must be 2 or more.
//  Ports       : clk      - destination clock
//                rst_n    - asynchronous active-low reset
//                data_in  - asynchronous input bits
//                data_out - synchronized bits
//  Revision    : 1.0  initial release
// ============================================================================
module c3lib_bitsync #(
    parameter int   DWIDTH    = 1,
    parameter int   SYNCSTAGE = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out
);

    // Stage 0 is the metastability-capture flop; the last stage is the output
    logic [SYNCSTAGE-1:0][DWIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNCSTAGE{ {DWIDTH{RESET_VAL}} }};
        end else begin
            r_sync <= {r_sync[SYNCSTAGE-2:0], data_in};
        end
    end

    assign data_out = r_sync[SYNCSTAGE-1];

endmodule : c3lib_bitsync
`default_nettype wire

// File: rtl/c3aibadapt_txasync_lockqual.sv
`default_nettype none
// ============================================================================
//  Module      : c3aibadapt_txasync_lockqual
//  Description : Synchronizes the raw PCS PLL lock into the config clock,
//                qualifies it with a programmable stable-high filter and
//                drives the qualified lock toward the AIB direct-async path.
//                Falling edges of the qualified lock are recorded in a sticky
//                flag and a saturating event counter for CSR readback.
//  Ports       : clk                  - config/status clock
//                rst_n                - asynchronous active-low reset
//                pld_pma_fpll_lc_lock - raw asynchronous PLL lock
//                r_lock_qual_en       - 1 = qualify, 0 = bypass (static)
//                r_lock_qual_cnt      - qualification length N (static)
//                lock_loss_clr        - pulse, clears sticky flag and counter
//                lock_qual            - qualified lock (registered)
//                lock_loss_sticky     - set on any lock_qual falling edge
//                lock_loss_cnt        - saturating count of falling edges
//                lock_state           - FSM state for debug
//  Revision    : 1.0  initial release
// ============================================================================
module c3aibadapt_txasync_lockqual
    import c3aibadapt_lockqual_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int QUAL_CNT_W  = LQ_QUAL_CNT_W_DEF,
    parameter int LOSS_CNT_W  = LQ_LOSS_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pld_pma_fpll_lc_lock,
    input  logic                  r_lock_qual_en,
    input  logic [QUAL_CNT_W-1:0] r_lock_qual_cnt,
    input  logic                  lock_loss_clr,
    output logic                  lock_qual,
    output logic                  lock_loss_sticky,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic [1:0]            lock_state
);

    localparam logic [QUAL_CNT_W-1:0] C_QUAL_ONE = QUAL_CNT_W'(1);
    localparam logic [LOSS_CNT_W-1:0] C_LOSS_ONE = LOSS_CNT_W'(1);

    logic                  w_lock_sync;
    lq_state_e             r_state;
    lq_state_e             w_state_nxt;
    logic [QUAL_CNT_W-1:0] r_qual_cnt;
    logic [QUAL_CNT_W-1:0] w_qual_cnt_nxt;
    logic                  r_lock_qual;
    logic                  w_lock_qual_nxt;
    logic                  w_loss_evt;
    logic                  r_loss_sticky;
    logic [LOSS_CNT_W-1:0] r_loss_cnt;

    // ------------------------------------------------------------------------
    // Synchronizer: the only logic that sees the raw asynchronous lock
    // ------------------------------------------------------------------------
    c3lib_bitsync #(
        .DWIDTH    (1),
        .SYNCSTAGE (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (pld_pma_fpll_lc_lock),
        .data_out (w_lock_sync)
    );

    // ------------------------------------------------------------------------
    // Lock FSM next-state and qualification counter
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_qual_cnt_nxt = r_qual_cnt;

        if (!r_lock_qual_en) begin
            // Bypass: lock_qual simply follows lock_sync one cycle later
            w_state_nxt    = w_lock_sync ? LQ_LOCKED : LQ_UNLOCKED;
            w_qual_cnt_nxt = '0;
        end else begin
            case (r_state)
                LQ_UNLOCKED: begin
                    if (w_lock_sync) begin
                        w_state_nxt    = LQ_QUALIFY;
                        w_qual_cnt_nxt = C_QUAL_ONE;
                    end
                end
                LQ_QUALIFY: begin
                    if (!w_lock_sync) begin
                        w_state_nxt    = LQ_UNLOCKED;
                        w_qual_cnt_nxt = '0;
                    end else if (r_qual_cnt >= r_lock_qual_cnt) begin
                        // cnt starts at 1, so N=0 resolves exactly like N=1
                        w_state_nxt = LQ_LOCKED;
                    end else begin
                        // Only reached while cnt < N, so the counter never wraps
                        w_qual_cnt_nxt = r_qual_cnt + C_QUAL_ONE;
                    end
                end
                LQ_LOCKED: begin
                    // Deassertion is never filtered
                    if (!w_lock_sync) begin
                        w_state_nxt    = LQ_UNLOCKED;
                        w_qual_cnt_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt    = LQ_UNLOCKED;
                    w_qual_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LQ_UNLOCKED;
            r_qual_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_qual_cnt <= w_qual_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Qualified lock and loss tracking. lock_qual is registered from the FSM
    // next state so it is exactly (state == LOCKED) with no added latency;
    // a loss is seen in the same cycle as the drop.
    // ------------------------------------------------------------------------
    assign w_lock_qual_nxt = (w_state_nxt == LQ_LOCKED);
    assign w_loss_evt      = r_lock_qual & ~w_lock_qual_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_qual   <= 1'b0;
            r_loss_sticky <= 1'b0;
            r_loss_cnt    <= '0;
        end else begin
            r_lock_qual <= w_lock_qual_nxt;

            // A loss coinciding with a clear wins over the clear
            if (w_loss_evt) begin
                r_loss_sticky <= 1'b1;
            end else if (lock_loss_clr) begin
                r_loss_sticky <= 1'b0;
            end

            if (w_loss_evt) begin
                if (lock_loss_clr) begin
                    r_loss_cnt <= C_LOSS_ONE;
                end else if (!(&r_loss_cnt)) begin
                    r_loss_cnt <= r_loss_cnt + C_LOSS_ONE;
                end
            end else if (lock_loss_clr) begin
                r_loss_cnt <= '0;
            end
        end
    end

    assign lock_qual        = r_lock_qual;
    assign lock_loss_sticky = r_loss_sticky;
    assign lock_loss_cnt    = r_loss_cnt;
    assign lock_state       = r_state;

endmodule : c3aibadapt_txasync_lockqual
`default_nettype wire
